bcd_multiplexed_display: RTL



---
 rtl/bcd_multiplexed_display.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_multiplexed_display.sv
// Binary-to-BCD converter (iterative double-dabble) driving a time-multiplexed,
// common-anode bank of seven-segment displays with active-low segments and enables.
// A conversion is requested with start, runs for COUNTWIDTH shift cycles and is
// committed to the display register in one step, so the display never shows a
// partially converted value.
module bcd_multiplexed_display #(
    parameter int unsigned COUNTWIDTH    = 14,
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COUNTWIDTH-1:0] number,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            data,
    output logic [DIGITS-1:0]     digit_en
);

    // Decimal digits needed for 2**COUNTWIDTH-1: floor(COUNTWIDTH*log10(2))+1.
    localparam int unsigned NUM_DEC = (COUNTWIDTH * 30103) / 100000 + 1;
    // Accumulator must also cover every displayed digit.
    localparam int unsigned NIBBLES = (NUM_DEC > DIGITS) ? NUM_DEC : DIGITS;
    localparam int unsigned BCD_W   = 4 * NIBBLES;
    localparam int unsigned DISP_W  = 4 * DIGITS;
    localparam int unsigned CNT_W   = $clog2(COUNTWIDTH + 1);
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned REF_W   = $clog2(REFRESH_DIV);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNTWIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DISP_W-1:0]       disp_q, disp_d;
    logic                    ovf_q, ovf_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        bcd_shift;
    logic [COUNTWIDTH-1:0]   bin_shift;
    logic                    ovf_shift;

    logic [REF_W-1:0]        ref_cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [6:0]              data_q, data_d;
    logic [DIGITS-1:0]       digit_en_q, digit_en_d;

    logic [3:0]              cur_nib;
    logic                    lead_zero;

    // Seven-segment decode, gfedcba active low; anything that is not BCD is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step: add-3 correction on every nibble, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[COUNTWIDTH-1]};
        bin_shift = {bin_q[COUNTWIDTH-2:0], 1'b0};
        ovf_shift = 1'b0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (i >= DIGITS) begin
                ovf_shift = ovf_shift | (|bcd_shift[4*i +: 4]);
            end
        end
    end

    // Conversion FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    // Conversion FSM next-state and datapath next values.
    // The final shifted result is written to the display register on the same edge
    // that enters StCommit, so done and the new display value appear together.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    bin_d   = number;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(COUNTWIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    disp_d  = bcd_shift[DISP_W-1:0];
                    ovf_d   = ovf_shift;
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StCommit);
    assign overflow = ovf_q;

    // Refresh timer: each digit stays enabled for REFRESH_DIV clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
        end else if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_q <= '0;
            idx_q     <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
        end
    end

    // Select the active digit, detect leading zeros and form segments and enables.
    always_comb begin
        cur_nib    = 4'd0;
        lead_zero  = (idx_q != '0);
        digit_en_d = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_nib       = disp_q[4*i +: 4];
                digit_en_d[i] = 1'b0;
            end
            if ((IDX_W'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'd0)) begin
                lead_zero = 1'b0;
            end
        end
        if (ovf_q) begin
            data_d = SEG_DASH;
        end else if (BLANK_LEADING && lead_zero) begin
            data_d = SEG_BLANK;
        end else begin
            data_d = seg_decode(cur_nib);
        end
    end

    // Segments and enables share one register stage so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= SEG_BLANK;
            digit_en_q <= '1;
        end else begin
            data_q     <= data_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign data     = data_q;
    assign digit_en = digit_en_q;

endmodule
